// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag-class one-hots and FSM encoding for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_MUL   = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_NAND  = 4'd6;
  localparam logic [3:0] OP_NOR   = 4'd7;
  localparam logic [3:0] OP_XOR   = 4'd8;
  localparam logic [3:0] OP_XNOR  = 4'd9;
  localparam logic [3:0] OP_CMPEQ = 4'd10;
  localparam logic [3:0] OP_CMPGT = 4'd11;
  localparam logic [3:0] OP_CMPLT = 4'd12;
  localparam logic [3:0] OP_SHR   = 4'd13;
  localparam logic [3:0] OP_SHL   = 4'd14;
  localparam logic [3:0] OP_NOP   = 4'd15;

  // Flag order everywhere is {Arith, Logic, CMP, Shift}
  localparam logic [3:0] FLG_ARITH = 4'b1000;
  localparam logic [3:0] FLG_LOGIC = 4'b0100;
  localparam logic [3:0] FLG_CMP   = 4'b0010;
  localparam logic [3:0] FLG_SHIFT = 4'b0001;
  localparam logic [3:0] FLG_NONE  = 4'b0000;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  function automatic logic [3:0] exp_class(input logic [3:0] fun);
    if (fun <= OP_DIV)       return FLG_ARITH;
    else if (fun <= OP_XNOR) return FLG_LOGIC;
    else if (fun <= OP_CMPLT) return FLG_CMP;
    else if (fun <= OP_SHL)  return FLG_SHIFT;
    else                     return FLG_NONE;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU-drive and response signals of the sequencer; master = sequencer side.
interface alu_cmd_sequencer_if #(parameter int WIDTH = 16);
  logic             cmd_valid, cmd_ready;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [3:0]       cmd_fun;
  logic [WIDTH-1:0] A, B;
  logic [3:0]       ALU_FUN;
  logic [WIDTH-1:0] ALU_OUT;
  logic             Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [3:0]       rsp_flags;
  logic             flag_err, div0;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, ALU_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, rsp_ready,
    output cmd_ready, A, B, ALU_FUN, rsp_valid, rsp_data, rsp_flags, flag_err, div0
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, ALU_OUT,
           Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag, rsp_ready,
    input  cmd_ready, A, B, ALU_FUN, rsp_valid, rsp_data, rsp_flags, flag_err, div0
  );
endinterface

// File: rtl/alu_flag_checker.sv
// Flags raised by the ALU must be exactly the one-hot class of the issued opcode.
module alu_flag_checker
  import alu_seq_pkg::*;
(
  input  logic [3:0] fun,
  input  logic [3:0] flags,
  output logic       err
);
  assign err = (flags != exp_class(fun));
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues commands to a registered ALU, waits ALU_LAT edges and returns result + flags.
// Optional macro ALU_DIV0_GUARD_EN intercepts DIV by zero without touching the ALU.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input logic                 CLK,
  input logic                 RST,
  alu_cmd_sequencer_if.master bus
);
  localparam int CW = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [3:0]       fun_q, fun_d, flags_q, flags_d;
  logic             vld_q, vld_d, ferr_q, ferr_d;
  logic [3:0]       alu_flags;
  logic             chk_err;
`ifdef ALU_DIV0_GUARD_EN
  logic             dz_q, dz_d, div0_q, div0_d;
`endif

  assign alu_flags = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};

  // fun_q still holds the issued opcode while in WAIT
  alu_flag_checker u_chk (.fun(fun_q), .flags(alu_flags), .err(chk_err));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    vld_d   = vld_q;
    data_d  = data_q;
    flags_d = flags_q;
    ferr_d  = ferr_q;
`ifdef ALU_DIV0_GUARD_EN
    dz_d    = dz_q;
    div0_d  = div0_q;
`endif
    case (state_q)
      S_IDLE: if (bus.cmd_valid) begin
        state_d = S_WAIT;
        cnt_d   = CW'(ALU_LAT);
`ifdef ALU_DIV0_GUARD_EN
        dz_d    = 1'b0;
        // Zero wait count gives the intercepted divide a one-edge turnaround
        if (bus.cmd_fun == OP_DIV && bus.cmd_b == '0) begin
          cnt_d = '0;
          dz_d  = 1'b1;
        end else
`endif
        begin
          a_d   = bus.cmd_a;
          b_d   = bus.cmd_b;
          fun_d = bus.cmd_fun;
        end
      end
      S_WAIT: if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        state_d = S_RESP;
        vld_d   = 1'b1;
        fun_d   = OP_NOP;
        data_d  = bus.ALU_OUT;
        flags_d = alu_flags;
        ferr_d  = chk_err;
`ifdef ALU_DIV0_GUARD_EN
        div0_d  = dz_q;
        if (dz_q) begin
          data_d  = '1;
          flags_d = FLG_ARITH;
          ferr_d  = 1'b0;
        end
`endif
      end
      S_RESP: if (bus.rsp_ready) begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
`ifdef ALU_DIV0_GUARD_EN
        div0_d  = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= OP_NOP;
      vld_q   <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
      ferr_q  <= 1'b0;
`ifdef ALU_DIV0_GUARD_EN
      dz_q    <= 1'b0;
      div0_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      ferr_q  <= ferr_d;
`ifdef ALU_DIV0_GUARD_EN
      dz_q    <= dz_d;
      div0_q  <= div0_d;
`endif
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.ALU_FUN   = fun_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;
  assign bus.flag_err  = ferr_q;
`ifdef ALU_DIV0_GUARD_EN
  assign bus.div0      = div0_q;
`else
  assign bus.div0      = 1'b0;
`endif

endmodule
